rgb_led_driver: RTL and testbench

Consumer end of the lighting colour interface. Takes the 3-bit `colour` code produced by the lighting controller and drives three PWM LED outputs (red, green, blue). Every colour change is shown as a timed fade-out of the old colour followed by a fade-in of the new one. Sits between the lighting controller and the board LED pins.

---
 rtl/rgb_led_pkg.sv | 36 +++
 rtl/rgb_led_driver_pwm_channel.sv | 22 ++
 rtl/rgb_led_driver.sv | 146 ++++++++++++++
 tb/tb_rgb_led_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_led_pkg.sv
// Shared types for the RGB LED fade driver.
// State encoding and named colour codes {R,G,B}.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        STEADY,
        FADE_OUT
    } state_t;

    typedef logic [2:0] colour_t;

    localparam colour_t COL_OFF     = 3'b000;
    localparam colour_t COL_BLUE    = 3'b001;
    localparam colour_t COL_GREEN   = 3'b010;
    localparam colour_t COL_CYAN    = 3'b011;
    localparam colour_t COL_RED     = 3'b100;
    localparam colour_t COL_MAGENTA = 3'b101;
    localparam colour_t COL_YELLOW  = 3'b110;
    localparam colour_t COL_WHITE   = 3'b111;

    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    // Any difference from what is shown, or a disable, starts a fade-out.
    function automatic logic must_fade_out(
        input colour_t col,
        input colour_t act,
        input logic    en
    );
        return (col != act) || !en;
    endfunction

endpackage

// File: rtl/rgb_led_driver_pwm_channel.sv
// One PWM channel: registered compare of the shared counter against level.
// Output is forced low whenever the channel is not part of the colour.
module pwm_channel #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] level,
    input  logic             en,
    output logic             pwm
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= en && (cnt < level);
        end
    end

endmodule

// File: rtl/rgb_led_driver.sv
// Three-channel LED driver: fades the old colour out, then the new one in.
// Counter, prescaler, brightness level and fade FSM live here.
module rgb_led_driver
    import rgb_led_pkg::*;
#(
    parameter int PWM_W            = 8,
    parameter int FADE_STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] colour,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       busy
);

    localparam int PRE_W =
        (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

    localparam logic [PWM_W-1:0] LVL_MAX  = '1;
    localparam logic [PWM_W-1:0] LVL_MAX1 = LVL_MAX - PWM_W'(1);
    localparam logic [PWM_W-1:0] LVL_ZERO = '0;
    localparam logic [PWM_W-1:0] LVL_ONE  = PWM_W'(1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_STEP_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    state_t           state;
    logic [PWM_W-1:0] cnt;
    logic [PRE_W-1:0] pre;
    logic [PWM_W-1:0] level;
    colour_t          active;
    colour_t          target;
    logic             step;
    logic             leave;

    assign step  = (pre == PRE_LAST);
    assign leave = must_fade_out(colour, active, enable);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            pre <= '0;
        end else begin
            cnt <= cnt + LVL_ONE;
            pre <= step ? '0 : pre + PRE_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            level  <= LVL_ZERO;
            active <= COL_OFF;
            target <= COL_OFF;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    level <= LVL_ZERO;
                    if (enable) begin
                        active <= colour;
                        target <= colour;
                        state  <= FADE_IN;
                        busy   <= 1'b1;
                    end
                end
                FADE_IN: begin
                    if (leave) begin
                        target <= colour;
                        state  <= FADE_OUT;
                    end else if (level == LVL_MAX) begin
                        state <= STEADY;
                        busy  <= 1'b0;
                    end else if (step) begin
                        level <= level + LVL_ONE;
                        if (level == LVL_MAX1) begin
                            state <= STEADY;
                            busy  <= 1'b0;
                        end
                    end
                end
                STEADY: begin
                    level <= LVL_MAX;
                    if (leave) begin
                        target <= colour;
                        state  <= FADE_OUT;
                        busy   <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    target <= colour;
                    if (step) begin
                        if (level != LVL_ZERO) begin
                            level <= level - LVL_ONE;
                        end
                        // Level hits zero on this step: the latest colour wins.
                        if (level <= LVL_ONE) begin
                            if (!enable) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                active <= colour;
                                state  <= FADE_IN;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    pwm_channel #(.PWM_W(PWM_W)) u_red (
        .clk   (clk),
        .rst   (rst),
        .cnt   (cnt),
        .level (level),
        .en    (active[CH_R]),
        .pwm   (led_r)
    );

    pwm_channel #(.PWM_W(PWM_W)) u_green (
        .clk   (clk),
        .rst   (rst),
        .cnt   (cnt),
        .level (level),
        .en    (active[CH_G]),
        .pwm   (led_g)
    );

    pwm_channel #(.PWM_W(PWM_W)) u_blue (
        .clk   (clk),
        .rst   (rst),
        .cnt   (cnt),
        .level (level),
        .en    (active[CH_B]),
        .pwm   (led_b)
    );

endmodule

// File: tb/tb_rgb_led_driver.sv
// Bench for rgb_led_driver: per-cycle model compare plus directed scenarios.
// PWM_W=4 (MAX=15), FADE_STEP_CYCLES=2.
module tb_rgb_led_driver;
    import rgb_led_pkg::*;

    localparam int PW   = 4;
    localparam int FSC  = 2;
    localparam int MAXV = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] colour = 3'b000;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Model: brightness, colour shown, and fade direction (+1 up, -1 down).
    int         m_cnt;
    int         m_pre;
    int         m_lvl;
    logic [2:0] m_act;
    int         m_ramp;
    bit         m_lit;

    always #5 clk = ~clk;

    rgb_led_driver #(
        .PWM_W            (PW),
        .FADE_STEP_CYCLES (FSC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .colour (colour),
        .led_r  (led_r),
        .led_g  (led_g),
        .led_b  (led_b),
        .busy   (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d",
                     name, act, lo, hi);
        end
    endtask

    task automatic wait_busy(input logic v, input int budget, output int n);
        n = 0;
        checks++;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (busy === v) return;
        end
        failures++;
        $display("FAIL wait_busy actual=timeout required=busy_%0d", v);
    endtask

    task automatic measure(output int r, output int g, output int b);
        r = 0;
        g = 0;
        b = 0;
        for (int i = 0; i < MAXV + 1; i++) begin
            @(negedge clk);
            r += int'(led_r);
            g += int'(led_g);
            b += int'(led_b);
        end
    endtask

    // Model update and compare on every cycle.
    initial begin
        bit         step;
        bit         e_r;
        bit         e_g;
        bit         e_b;
        bit         e_busy;
        bit         chg;
        m_cnt = 0;
        m_pre = 0;
        m_lvl = 0;
        m_act = 3'b000;
        m_ramp = 0;
        m_lit = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_cnt = 0;
                m_pre = 0;
                m_lvl = 0;
                m_act = 3'b000;
                m_ramp = 0;
                m_lit = 0;
                e_r = 0;
                e_g = 0;
                e_b = 0;
            end else begin
                e_r = m_act[2] && (m_cnt < m_lvl);
                e_g = m_act[1] && (m_cnt < m_lvl);
                e_b = m_act[0] && (m_cnt < m_lvl);
                step = (m_pre == FSC - 1);
                chg = (colour != m_act) || !enable;
                if (m_ramp == 0 && !m_lit) begin
                    m_lvl = 0;
                    if (enable) begin
                        m_act = colour;
                        m_ramp = 1;
                    end
                end else if (m_ramp == 1) begin
                    if (chg) begin
                        m_ramp = -1;
                    end else if (step) begin
                        m_lvl = m_lvl + 1;
                        if (m_lvl == MAXV) begin
                            m_ramp = 0;
                            m_lit = 1;
                        end
                    end
                end else if (m_ramp == 0) begin
                    if (chg) begin
                        m_ramp = -1;
                        m_lit = 0;
                    end
                end else if (step) begin
                    m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
                    if (m_lvl == 0) begin
                        if (!enable) begin
                            m_ramp = 0;
                        end else begin
                            m_act = colour;
                            m_ramp = 1;
                        end
                    end
                end
                m_cnt = (m_cnt + 1) % (MAXV + 1);
                m_pre = (m_pre + 1) % FSC;
            end
            e_busy = (m_ramp != 0);
            #1;
            chk("led_r", int'(led_r), int'(e_r));
            chk("led_g", int'(led_g), int'(e_g));
            chk("led_b", int'(led_b), int'(e_b));
            chk("busy", int'(busy), int'(e_busy));
            chk("level", int'(dut.level), m_lvl);
        end
    end

    initial begin
        int n;
        int r;
        int g;
        int b;

        rst = 1'b0;
        enable = 1'b1;
        colour = COL_RED;
        repeat (4) @(negedge clk);
        chk("rst_led_r", int'(led_r), 0);
        chk("rst_led_g", int'(led_g), 0);
        chk("rst_led_b", int'(led_b), 0);
        chk("rst_busy", int'(busy), 0);

        rst = 1'b1;
        wait_busy(1'b1, 5, n);
        chk("start_latency", n, 1);
        wait_busy(1'b0, 40, n);
        chk_rng("fadein_len", n, 29, 31);
        chk("steady_level", int'(dut.level), 15);
        repeat (2) @(negedge clk);
        measure(r, g, b);
        chk("red_duty_r", r, 15);
        chk("red_duty_g", g, 0);
        chk("red_duty_b", b, 0);

        colour = COL_CYAN;
        wait_busy(1'b1, 3, n);
        chk("cyan_start", n, 1);
        wait_busy(1'b0, 80, n);
        chk_rng("cyan_xfade_len", n, 58, 61);
        chk("cyan_active", int'(dut.active), 3);
        repeat (2) @(negedge clk);
        measure(r, g, b);
        chk("cyan_duty_r", r, 0);
        chk("cyan_duty_g", g, 15);
        chk("cyan_duty_b", b, 15);

        colour = COL_RED;
        n = 0;
        while (n < 100 && !(m_ramp == 1 && m_act == COL_RED && m_lvl == 8)) begin
            @(negedge clk);
            n++;
        end
        chk("mid_fadein_level", int'(dut.level), 8);
        colour = COL_BLUE;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 40 && dut.level != 0);
        chk_rng("from8_len", n, 15, 18);
        wait_busy(1'b0, 60, n);
        chk("blue_active", int'(dut.active), 1);

        colour = COL_GREEN;
        repeat (6) @(negedge clk);
        colour = COL_BLUE;
        repeat (6) @(negedge clk);
        colour = COL_YELLOW;
        wait_busy(1'b0, 100, n);
        chk("yellow_active", int'(dut.active), 6);
        repeat (2) @(negedge clk);
        measure(r, g, b);
        chk("yellow_duty_r", r, 15);
        chk("yellow_duty_g", g, 15);
        chk("yellow_duty_b", b, 0);

        enable = 1'b0;
        wait_busy(1'b1, 3, n);
        wait_busy(1'b0, 50, n);
        chk_rng("disable_len", n, 29, 31);
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_level", int'(dut.level), 0);
        measure(r, g, b);
        chk("idle_sum", r + g + b, 0);

        colour = COL_OFF;
        enable = 1'b1;
        wait_busy(1'b1, 3, n);
        chk("off_start", n, 1);
        wait_busy(1'b0, 40, n);
        chk_rng("off_fadein_len", n, 29, 31);
        chk("off_level", int'(dut.level), 15);
        measure(r, g, b);
        chk("off_sum", r + g + b, 0);

        colour = COL_WHITE;
        n = 0;
        while (n < 100 && !(m_ramp == 1 && m_act == COL_WHITE
                            && m_lvl >= 8 && led_r === 1'b1)) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_busy", int'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_led_r", int'(led_r), 0);
        chk("async_led_g", int'(led_g), 0);
        chk("async_led_b", int'(led_b), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_level", int'(dut.level), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
